demux2x32_buf: RTL and testbench

- Inverse of the 2:1 datapath mux: steers one 32-bit source word to one of two sinks, selected by `s`.
- Each sink has its own 2-entry FIFO, so a stalled sink does not block words bound for the other sink once those words are queued.
- Used in the datapath to fan a single result bus out to two consumers, for example data RAM versus memory-mapped I/O.
- Valid/ready handshake on the input and on both outputs.

---
 rtl/demux2x32_buf_pkg.sv | 7 +
 rtl/demux2x32_buf_fifo_buf.sv | 63 ++++++
 rtl/demux2x32_buf.sv | 65 ++++++
 tb/tb_demux2x32_buf.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/demux2x32_buf_pkg.sv
// Shared sizing for the buffered 1:2 demultiplexer.
package demux2x32_buf_pkg;
    localparam int DMUX_WIDTH = 32;
    localparam int DMUX_DEPTH = 2;
    localparam int DMUX_CW    = 16;
    localparam int DMUX_PW    = $clog2(DMUX_DEPTH);
endpackage

// File: rtl/demux2x32_buf_fifo_buf.sv
// Small circular FIFO with registered head output; storage clears on reset.
module fifo_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;
    localparam logic [PW:0] OCC_FULL = OW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]      occ_q, occ_d;
    logic             do_push, do_pop;

    assign full    = (occ_q == OCC_FULL);
    assign empty   = (occ_q == '0);
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop)
            rd_ptr_d = rd_ptr_q + PW'(1);
        // push+pop together leaves occupancy unchanged
        case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end
endmodule

// File: rtl/demux2x32_buf.sv
// Steers one input word to one of two buffered sinks and counts words routed to each.
module demux2x32_buf
    import demux2x32_buf_pkg::*;
#(
    parameter int WIDTH = DMUX_WIDTH,
    parameter int DEPTH = DMUX_DEPTH,
    parameter int CW    = DMUX_CW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic             s,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y0,
    output logic             y0_valid,
    input  logic             y0_ready,
    output logic [WIDTH-1:0] y1,
    output logic             y1_valid,
    input  logic             y1_ready,
    output logic [CW-1:0]    cnt0,
    output logic [CW-1:0]    cnt1
);
    logic          full0, full1, empty0, empty1;
    logic          push0, push1, pop0, pop1;
    logic [CW-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    // Ready depends only on the selected FIFO's fullness, never on sink ready.
    assign in_ready = s ? !full1 : !full0;
    assign push0    = in_valid && in_ready && !s;
    assign push1    = in_valid && in_ready && s;
    assign y0_valid = !empty0;
    assign y1_valid = !empty1;
    assign pop0     = y0_valid && y0_ready;
    assign pop1     = y1_valid && y1_ready;
    assign cnt0     = cnt0_q;
    assign cnt1     = cnt1_q;

    fifo_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
        .clk(clk), .rst(rst), .push(push0), .din(a), .full(full0),
        .pop(pop0), .dout(y0), .empty(empty0)
    );

    fifo_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk(clk), .rst(rst), .push(push1), .din(a), .full(full1),
        .pop(pop1), .dout(y1), .empty(empty1)
    );

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (push0) cnt0_d = cnt0_q + CW'(1);
        if (push1) cnt1_d = cnt1_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end
endmodule

// File: tb/tb_demux2x32_buf.sv
// Randomized and directed bench for demux2x32_buf against a queue-based reference model.
module tb_demux2x32_buf;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a;
    logic        s, in_valid, in_ready;
    logic [31:0] y0, y1;
    logic        y0_valid, y0_ready, y1_valid, y1_ready;
    logic [15:0] cnt0, cnt1;

    int total = 0;
    int bad   = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [15:0] c0, c1;
    int          sink0;

    always #5 clk = ~clk;

    demux2x32_buf dut (
        .clk(clk), .rst(rst), .a(a), .s(s), .in_valid(in_valid), .in_ready(in_ready),
        .y0(y0), .y0_valid(y0_valid), .y0_ready(y0_ready),
        .y1(y1), .y1_valid(y1_valid), .y1_ready(y1_ready),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    task automatic model_clear();
        q0.delete(); q1.delete(); c0 = '0; c1 = '0; sink0 = 0;
    endtask

    // One clock: drive, check the pre-edge view against the model, then advance model.
    task automatic cycle(input logic v, input logic sel, input logic [31:0] d,
                         input logic r0, input logic r1);
        bit exp_rdy, pu, po0, po1;
        in_valid = v; s = sel; a = d; y0_ready = r0; y1_ready = r1;
        #1;
        exp_rdy = sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
        total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL in_ready s=%0b got=%b exp=%b", sel, in_ready, exp_rdy); end
        total++; if (y0_valid !== (q0.size() != 0)) begin bad++; $display("FAIL y0_valid got=%b exp=%0d", y0_valid, q0.size() != 0); end
        total++; if (y1_valid !== (q1.size() != 0)) begin bad++; $display("FAIL y1_valid got=%b exp=%0d", y1_valid, q1.size() != 0); end
        if (q0.size() != 0) begin
            total++; if (y0 !== q0[0]) begin bad++; $display("FAIL y0 data got=%h exp=%h", y0, q0[0]); end
        end
        if (q1.size() != 0) begin
            total++; if (y1 !== q1[0]) begin bad++; $display("FAIL y1 data got=%h exp=%h", y1, q1[0]); end
        end
        total++; if (cnt0 !== c0) begin bad++; $display("FAIL cnt0 got=%h exp=%h", cnt0, c0); end
        total++; if (cnt1 !== c1) begin bad++; $display("FAIL cnt1 got=%h exp=%h", cnt1, c1); end
        pu  = v && exp_rdy;
        po0 = r0 && (q0.size() != 0);
        po1 = r1 && (q1.size() != 0);
        if (y0_valid === 1'b1 && r0) sink0++;
        @(posedge clk); #1;
        if (po0) void'(q0.pop_front());
        if (po1) void'(q1.pop_front());
        if (pu) begin
            if (sel) begin q1.push_back(d); c1++; end
            else     begin q0.push_back(d); c0++; end
        end
    endtask

    task automatic do_reset();
        in_valid = 0; s = 0; a = '0; y0_ready = 0; y1_ready = 0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        in_valid = 0; s = 0; a = '0; y0_ready = 0; y1_ready = 0;
        rst = 1'b1;
        #1;
        total++; if (y0_valid !== 1'b0 || y1_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b%b exp=00", y0_valid, y1_valid); end
        total++; if (y0 !== 32'h0 || y1 !== 32'h0) begin bad++; $display("FAIL reset_data got=%h/%h exp=0/0", y0, y1); end
        total++; if (cnt0 !== 16'h0 || cnt1 !== 16'h0) begin bad++; $display("FAIL reset_cnt got=%h/%h exp=0/0", cnt0, cnt1); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_rdy_s0 got=%b exp=1", in_ready); end
        s = 1; #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_rdy_s1 got=%b exp=1", in_ready); end
        s = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_basic();
        do_reset();
        cycle(1, 0, 32'd10, 0, 0);
        cycle(1, 1, 32'd32, 0, 0);
        cycle(0, 0, 32'h0, 0, 0);
        cycle(0, 1, 32'h0, 0, 0);
    endtask

    task automatic test_fill_drain();
        do_reset();
        cycle(1, 0, 32'hA, 0, 0);
        cycle(1, 0, 32'hB, 0, 0);
        cycle(1, 0, 32'hE, 0, 0);   // refused: FIFO 0 full
        cycle(0, 1, 32'h0, 0, 0);
        cycle(1, 1, 32'hC, 0, 0);
        cycle(0, 0, 32'h0, 1, 0);
        cycle(1, 0, 32'hD, 0, 0);
        cycle(1, 0, 32'hF, 1, 0);   // full FIFO refuses even while popping
        cycle(0, 0, 32'h0, 1, 0);
        cycle(0, 0, 32'h0, 1, 1);
        cycle(0, 0, 32'h0, 1, 1);
    endtask

    task automatic test_concurrent();
        do_reset();
        cycle(1, 1, 32'h1, 0, 0);
        cycle(1, 1, 32'h2, 0, 1);
        cycle(1, 0, 32'h3, 0, 1);
        cycle(1, 1, 32'h4, 1, 0);
        cycle(0, 0, 32'h0, 1, 1);
        cycle(0, 0, 32'h0, 0, 0);
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 65536; i++) cycle(1, 0, $urandom, 1, 0);
        cycle(0, 0, 32'h0, 1, 0);
        cycle(0, 0, 32'h0, 1, 0);
        total++; if (cnt0 !== 16'h0000) begin bad++; $display("FAIL wrap_cnt0 got=%h exp=0000", cnt0); end
        total++; if (sink0 != 65536) begin bad++; $display("FAIL wrap_sink got=%0d exp=65536", sink0); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cycle(1, 0, 32'h11, 0, 0);
        cycle(1, 1, 32'h21, 0, 0);
        cycle(1, 0, 32'h12, 0, 0);
        cycle(1, 1, 32'h22, 0, 0);
        in_valid = 0; y0_ready = 0; y1_ready = 0;
        #2 rst = 1'b1;
        #1;
        total++; if (y0_valid !== 1'b0 || y1_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b%b exp=00", y0_valid, y1_valid); end
        total++; if (cnt0 !== 16'h0 || cnt1 !== 16'h0) begin bad++; $display("FAIL midrst_cnt got=%h/%h exp=0/0", cnt0, cnt1); end
        total++; if (y0 !== 32'h0 || y1 !== 32'h0) begin bad++; $display("FAIL midrst_data got=%h/%h exp=0/0", y0, y1); end
        #1 rst = 1'b0;
        model_clear();
        @(posedge clk); #1;
        cycle(1, 1, 32'h5, 0, 0);
        cycle(0, 0, 32'h0, 0, 0);
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++)
            cycle($urandom_range(0, 1), $urandom_range(0, 1), $urandom,
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) != 0));
        for (int i = 0; i < 3; i++) cycle(0, 0, 32'h0, 1, 1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill_drain();
        test_concurrent();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
